// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
//   Turn sequencer for tic-tac-toe. Holds the 18-bit board, accepts human (X)
//   moves over a valid/ready handshake and presents the board to a
//   combinational AI block. After AI_LATENCY settle cycles it samples the
//   AI answer and commits the O move. After every move it checks all eight
//   lines and the move count, and finishes the game with a win, a draw, or
//   an AI fault.
//
// Parameters
//   AI_LATENCY  : settle cycles for the AI block (1..15)
//   HUMAN_FIRST : 1 = X opens the game, 0 = the AI opens the game
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset, overrides everything
//   new_game    in   synchronous restart (board clear, turn order restart)
//   move_valid  in   human move offered
//   move_row    in   human row 0..2
//   move_col    in   human column 0..2
//   move_ready  out  high only while waiting for a human move
//   board       out  cell k = 3*row+col at [2k+1:2k]; 00 empty, 01 X, 10 O
//   ai_row      in   AI chosen row
//   ai_col      in   AI chosen column
//   ai_xoro     in   AI piece code, must be 2'b10
//   illegal     out  one-cycle pulse after a rejected human move
//   game_over   out  game finished, held until new_game/reset
//   winner      out  00 none/draw, 01 X, 10 O, 11 AI fault
//   move_count  out  number of occupied cells, 0..9
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
  parameter int unsigned AI_LATENCY  = 1,
  parameter bit          HUMAN_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [1:0]  move_row,
  input  logic [1:0]  move_col,
  output logic        move_ready,
  output logic [17:0] board,
  input  logic [1:0]  ai_row,
  input  logic [1:0]  ai_col,
  input  logic [1:0]  ai_xoro,
  output logic        illegal,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);

  typedef enum logic [2:0] {
    ST_WAIT_H   = 3'd0,
    ST_CHECK_H  = 3'd1,
    ST_AI_WAIT  = 3'd2,
    ST_AI_WRITE = 3'd3,
    ST_CHECK_A  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] CELL_BAD   = 2'b11;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_X      = 2'b01;
  localparam logic [1:0] WIN_O      = 2'b10;
  localparam logic [1:0] WIN_FAULT  = 2'b11;

  localparam logic [3:0] LAT_LOAD   = 4'(AI_LATENCY);
  localparam state_t     ST_START   = HUMAN_FIRST ? ST_WAIT_H : ST_AI_WAIT;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------
  function automatic logic in_range(input logic [1:0] r, input logic [1:0] c);
    return (r <= 2'd2) && (c <= 2'd2);
  endfunction

  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'd3) + {2'b00, c};
  endfunction

  // Out-of-board indices read back as a non-empty code so they are never legal.
  function automatic logic [1:0] cell_get(input logic [17:0] b, input logic [3:0] k);
    logic [1:0] v;
    if (k <= 4'd8) begin
      v = b[{k, 1'b0} +: 2];
    end else begin
      v = CELL_BAD;
    end
    return v;
  endfunction

  function automatic logic [17:0] cell_set(input logic [17:0] b, input logic [3:0] k,
                                           input logic [1:0] v);
    logic [17:0] r;
    r = b;
    if (k <= 4'd8) begin
      r[{k, 1'b0} +: 2] = v;
    end else begin
      r = b;
    end
    return r;
  endfunction

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] who);
    logic [8:0] m;
    for (int k = 0; k < 9; k++) begin
      m[k] = (b[2*k +: 2] == who);
    end
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  function automatic logic [3:0] count_inc(input logic [3:0] c);
    return (c >= 4'd9) ? 4'd9 : (c + 4'd1);
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t      state_r,   state_nxt;
  logic [17:0] board_r,   board_nxt;
  logic [3:0]  count_r,   count_nxt;
  logic [3:0]  lat_r,     lat_nxt;
  logic        illegal_r, illegal_nxt;
  logic        over_r,    over_nxt;
  logic [1:0]  winner_r,  winner_nxt;
  logic        ready_r,   ready_nxt;

  logic [3:0]  h_idx_s;
  logic        h_legal_s;
  logic [3:0]  a_idx_s;
  logic        a_legal_s;

  assign move_ready = ready_r;
  assign board      = board_r;
  assign illegal    = illegal_r;
  assign game_over  = over_r;
  assign winner     = winner_r;
  assign move_count = count_r;

  // Legality of the offered human move and of the AI answer against the current board.
  always_comb begin
    h_idx_s   = cell_idx(move_row, move_col);
    h_legal_s = in_range(move_row, move_col) && (cell_get(board_r, h_idx_s) == CELL_EMPTY);
    a_idx_s   = cell_idx(ai_row, ai_col);
    a_legal_s = (ai_xoro == CELL_O) && in_range(ai_row, ai_col) &&
                (cell_get(board_r, a_idx_s) == CELL_EMPTY);
  end

  // Next-state and next-register logic for the turn sequencer.
  always_comb begin
    state_nxt   = state_r;
    board_nxt   = board_r;
    count_nxt   = count_r;
    lat_nxt     = lat_r;
    illegal_nxt = 1'b0;
    over_nxt    = over_r;
    winner_nxt  = winner_r;

    if (new_game) begin
      // Restart wins over any move offered in the same cycle.
      state_nxt  = ST_START;
      board_nxt  = 18'd0;
      count_nxt  = 4'd0;
      lat_nxt    = 4'd0;
      over_nxt   = 1'b0;
      winner_nxt = WIN_NONE;
    end else begin
      case (state_r)
        ST_WAIT_H: begin
          if (move_valid) begin
            if (h_legal_s) begin
              board_nxt = cell_set(board_r, h_idx_s, CELL_X);
              count_nxt = count_inc(count_r);
              state_nxt = ST_CHECK_H;
            end else begin
              illegal_nxt = 1'b1;
            end
          end else begin
            state_nxt = ST_WAIT_H;
          end
        end

        ST_CHECK_H: begin
          if (has_line(board_r, CELL_X)) begin
            state_nxt  = ST_DONE;
            over_nxt   = 1'b1;
            winner_nxt = WIN_X;
          end else if (count_r == 4'd9) begin
            state_nxt  = ST_DONE;
            over_nxt   = 1'b1;
            winner_nxt = WIN_NONE;
          end else begin
            state_nxt  = ST_AI_WAIT;
            lat_nxt    = LAT_LOAD;
          end
        end

        // Leaves once the counter has run down to zero, so the frozen board
        // sits at the AI inputs for AI_LATENCY+1 cycles and move_ready
        // returns 4+AI_LATENCY cycles after an accepted human move.
        ST_AI_WAIT: begin
          if (lat_r == 4'd0) begin
            state_nxt = ST_AI_WRITE;
          end else begin
            lat_nxt = lat_r - 4'd1;
          end
        end

        ST_AI_WRITE: begin
          if (a_legal_s) begin
            board_nxt = cell_set(board_r, a_idx_s, CELL_O);
            count_nxt = count_inc(count_r);
            state_nxt = ST_CHECK_A;
          end else begin
            state_nxt  = ST_DONE;
            over_nxt   = 1'b1;
            winner_nxt = WIN_FAULT;
          end
        end

        ST_CHECK_A: begin
          if (has_line(board_r, CELL_O)) begin
            state_nxt  = ST_DONE;
            over_nxt   = 1'b1;
            winner_nxt = WIN_O;
          end else if (count_r == 4'd9) begin
            state_nxt  = ST_DONE;
            over_nxt   = 1'b1;
            winner_nxt = WIN_NONE;
          end else begin
            state_nxt  = ST_WAIT_H;
          end
        end

        ST_DONE: begin
          state_nxt = ST_DONE;
        end

        default: begin
          // Unreachable encodings end the game as a fault rather than resuming play.
          state_nxt  = ST_DONE;
          over_nxt   = 1'b1;
          winner_nxt = WIN_FAULT;
        end
      endcase
    end

    ready_nxt = (state_nxt == ST_WAIT_H);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_START;
      board_r   <= 18'd0;
      count_r   <= 4'd0;
      lat_r     <= 4'd0;
      illegal_r <= 1'b0;
      over_r    <= 1'b0;
      winner_r  <= WIN_NONE;
      ready_r   <= HUMAN_FIRST;
    end else begin
      state_r   <= state_nxt;
      board_r   <= board_nxt;
      count_r   <= count_nxt;
      lat_r     <= lat_nxt;
      illegal_r <= illegal_nxt;
      over_r    <= over_nxt;
      winner_r  <= winner_nxt;
      ready_r   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_game_ctrl
//   Directed test of ttt_game_ctrl. dut0 runs human-first with AI_LATENCY=1,
//   dut1 runs AI-first with AI_LATENCY=2. The AI block is replaced by bench
//   driven ai_* values set before each human move.
// ---------------------------------------------------------------------------
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        new_game0, mv0;
  logic [1:0]  mr0, mc0, ar0, ac0, ax0;
  logic        ready0, illegal0, over0;
  logic [17:0] board0;
  logic [1:0]  win0;
  logic [3:0]  cnt0;

  logic        new_game1, mv1;
  logic [1:0]  mr1, mc1, ar1, ac1, ax1;
  logic        ready1, illegal1, over1;
  logic [17:0] board1;
  logic [1:0]  win1;
  logic [3:0]  cnt1;

  int total = 0;
  int bad   = 0;

  ttt_game_ctrl #(.AI_LATENCY(1), .HUMAN_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .new_game(new_game0),
    .move_valid(mv0), .move_row(mr0), .move_col(mc0), .move_ready(ready0),
    .board(board0), .ai_row(ar0), .ai_col(ac0), .ai_xoro(ax0),
    .illegal(illegal0), .game_over(over0), .winner(win0), .move_count(cnt0)
  );

  ttt_game_ctrl #(.AI_LATENCY(2), .HUMAN_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .new_game(new_game1),
    .move_valid(mv1), .move_row(mr1), .move_col(mc1), .move_ready(ready1),
    .board(board1), .ai_row(ar1), .ai_col(ac1), .ai_xoro(ax1),
    .illegal(illegal1), .game_over(over1), .winner(win1), .move_count(cnt1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move0(input logic [1:0] r, input logic [1:0] c);
    mr0 = r;
    mc0 = c;
    mv0 = 1'b1;
    tick();
    mv0 = 1'b0;
  endtask

  task automatic set_ai0(input logic [1:0] r, input logic [1:0] c, input logic [1:0] x);
    ar0 = r;
    ac0 = c;
    ax0 = x;
  endtask

  task automatic pulse_new0();
    new_game0 = 1'b1;
    tick();
    new_game0 = 1'b0;
  endtask

  task automatic wait_ready0(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (ready0) break;
      tick();
    end
    check_val(tag, {31'd0, ready0}, 32'd1);
  endtask

  task automatic wait_over0(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (over0) break;
      tick();
    end
    check_val(tag, {31'd0, over0}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    new_game0 = 1'b0; mv0 = 1'b0; mr0 = 2'd0; mc0 = 2'd0;
    new_game1 = 1'b0; mv1 = 1'b0; mr1 = 2'd0; mc1 = 2'd0;
    set_ai0(2'd2, 2'd2, 2'b10);
    ar1 = 2'd1; ac1 = 2'd1; ax1 = 2'b10;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_board0", 32'(board0), 32'd0);
    check_val("rst_cnt0",   32'(cnt0),   32'd0);
    check_val("rst_over0",  32'(over0),  32'd0);
    check_val("rst_win0",   32'(win0),   32'd0);
    check_val("rst_ill0",   32'(illegal0), 32'd0);
    check_val("rst_ready0", 32'(ready0), 32'd1);
    check_val("rst_ready1", 32'(ready1), 32'd0);

    // AI-first instance writes O at (1,1) before X may move
    n = 0;
    while (!ready1 && n < 30) begin
      n++;
      tick();
    end
    check_val("ai_first_ready1", 32'(ready1), 32'd1);
    check_val("ai_first_board1", 32'(board1), 32'h00200);
    check_val("ai_first_cnt1",   32'(cnt1),   32'd1);

    // AI_LATENCY=2: move_ready low for 6 cycles after acceptance
    ar1 = 2'd2; ac1 = 2'd2;
    mr1 = 2'd0; mc1 = 2'd0; mv1 = 1'b1;
    tick();
    mv1 = 1'b0;
    n = 0;
    while (!ready1 && n < 30) begin
      n++;
      tick();
    end
    check_val("lat2_low_cycles", 32'(n), 32'd6);
    check_val("lat2_board1", 32'(board1), 32'h20201);
    check_val("lat2_cnt1",   32'(cnt1),   32'd3);

    // First move (1,1), AI answers (2,2)
    set_ai0(2'd2, 2'd2, 2'b10);
    move0(2'd1, 2'd1);
    check_val("mv1_board_x", 32'(board0), 32'h00100);
    check_val("mv1_cnt",     32'(cnt0),   32'd1);
    n = 0;
    while (!ready0 && n < 30) begin
      n++;
      tick();
    end
    check_val("mv1_low_cycles", 32'(n), 32'd5);
    check_val("mv1_board_o", 32'(board0), 32'h20100);
    check_val("mv1_cnt2",    32'(cnt0),   32'd2);

    // Occupied cell, then out-of-range row
    move0(2'd1, 2'd1);
    check_val("occ_illegal", 32'(illegal0), 32'd1);
    check_val("occ_board",   32'(board0),   32'h20100);
    check_val("occ_ready",   32'(ready0),   32'd1);
    tick();
    check_val("occ_pulse_end", 32'(illegal0), 32'd0);
    move0(2'd3, 2'd0);
    check_val("row3_illegal", 32'(illegal0), 32'd1);
    check_val("row3_board",   32'(board0),   32'h20100);
    check_val("row3_cnt",     32'(cnt0),     32'd2);
    tick();
    check_val("row3_pulse_end", 32'(illegal0), 32'd0);
    check_val("row3_ready",     32'(ready0),   32'd1);

    // X wins along row 0
    pulse_new0();
    check_val("ng_board", 32'(board0), 32'd0);
    check_val("ng_ready", 32'(ready0), 32'd1);
    set_ai0(2'd2, 2'd2, 2'b10);
    move0(2'd0, 2'd0);
    wait_ready0("win_wait1");
    set_ai0(2'd2, 2'd1, 2'b10);
    move0(2'd0, 2'd1);
    wait_ready0("win_wait2");
    move0(2'd0, 2'd2);
    tick();
    check_val("win_over",  32'(over0),  32'd1);
    check_val("win_who",   32'(win0),   32'd1);
    check_val("win_ready", 32'(ready0), 32'd0);
    check_val("win_cnt",   32'(cnt0),   32'd5);
    move0(2'd2, 2'd0);
    tick();
    check_val("done_board",  32'(board0),   32'h28015);
    check_val("done_ill",    32'(illegal0), 32'd0);
    check_val("done_over",   32'(over0),    32'd1);

    // AI answers an occupied cell
    pulse_new0();
    check_val("ng2_over", 32'(over0), 32'd0);
    set_ai0(2'd0, 2'd0, 2'b10);
    move0(2'd0, 2'd0);
    wait_over0("fault_occ_wait");
    check_val("fault_occ_win",   32'(win0),   32'd3);
    check_val("fault_occ_board", 32'(board0), 32'h00001);
    check_val("fault_occ_cnt",   32'(cnt0),   32'd1);

    // AI answers with the wrong piece code
    pulse_new0();
    set_ai0(2'd2, 2'd2, 2'b01);
    move0(2'd0, 2'd0);
    wait_over0("fault_xo_wait");
    check_val("fault_xo_win",   32'(win0),   32'd3);
    check_val("fault_xo_board", 32'(board0), 32'h00001);

    // Full board without a line
    pulse_new0();
    set_ai0(2'd1, 2'd1, 2'b10);
    move0(2'd0, 2'd0);
    wait_ready0("draw_wait1");
    set_ai0(2'd0, 2'd2, 2'b10);
    move0(2'd2, 2'd2);
    wait_ready0("draw_wait2");
    set_ai0(2'd2, 2'd1, 2'b10);
    move0(2'd2, 2'd0);
    wait_ready0("draw_wait3");
    set_ai0(2'd1, 2'd0, 2'b10);
    move0(2'd0, 2'd1);
    wait_ready0("draw_wait4");
    check_val("draw_cnt8", 32'(cnt0), 32'd8);
    move0(2'd1, 2'd2);
    tick();
    check_val("draw_over",  32'(over0),  32'd1);
    check_val("draw_win",   32'(win0),   32'd0);
    check_val("draw_cnt",   32'(cnt0),   32'd9);
    check_val("draw_board", 32'(board0), 32'h196A5);

    // new_game with a move offered while the AI is settling
    pulse_new0();
    set_ai0(2'd2, 2'd2, 2'b10);
    move0(2'd1, 2'd1);
    tick();
    new_game0 = 1'b1;
    mv0 = 1'b1; mr0 = 2'd0; mc0 = 2'd0;
    tick();
    check_val("ngmid_board", 32'(board0), 32'd0);
    check_val("ngmid_ready", 32'(ready0), 32'd1);
    check_val("ngmid_cnt",   32'(cnt0),   32'd0);
    new_game0 = 1'b0;
    mv0 = 1'b0;
    repeat (6) tick();
    check_val("ngmid_board_hold", 32'(board0), 32'd0);
    check_val("ngmid_ready_hold", 32'(ready0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
